// File: rtl/prc_copy_dma.sv
// rtl/prc_copy_dma.sv - framebuffer-to-LCD page copy DMA
// Bus master that streams framebuffer pages into an LCD controller through its command/data registers.
module prc_copy_dma #(
  parameter int          COLUMNS       = 96,
  parameter int          PAGES         = 8,
  parameter logic [23:0] FB_BASE       = 24'h1000,
  parameter logic [23:0] LCD_CMD_ADDR  = 24'h20FE,
  parameter logic [23:0] LCD_DATA_ADDR = 24'h20FF,
  localparam int         PW            = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int         CW            = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] page_first,
  input  logic [PW-1:0] page_last,
  input  logic          invert,
  output logic          bus_request,
  input  logic          bus_ack,
  output logic [23:0]   bus_address_out,
  output logic [7:0]    bus_data_out,
  input  logic [7:0]    bus_data_in,
  output logic [1:0]    bus_status,
  output logic          read,
  output logic          write,
  output logic          busy,
  output logic          irq_copy_done
);

  typedef enum logic [2:0] {
    IDLE, REQ, COL_HI, COL_LO, PAGE, RD, WR, DONE
  } state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(COLUMNS - 1);

  state_t        state, state_n;
  logic          phase, phase_n;
  logic [PW-1:0] page, page_n;
  logic [CW-1:0] col, col_n;
  logic [PW-1:0] first_q, last_q;
  logic          inv_q;
  logic [7:0]    data_q;
  logic          load_cfg;
  logic          access, act, last_phase;
  logic [2:0]    page3;
  logic [23:0]   fb_addr;

  assign access     = (state == COL_HI) || (state == COL_LO) || (state == PAGE) ||
                      (state == RD) || (state == WR);
  assign act        = access && bus_ack;
  assign last_phase = act && phase;
  assign page3      = 3'(page);
  assign fb_addr    = FB_BASE + (24'(page) * 24'(COLUMNS)) + 24'(col);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= 1'b0;
      page    <= '0;
      col     <= '0;
      first_q <= '0;
      last_q  <= '0;
      inv_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state <= state_n;
      phase <= phase_n;
      page  <= page_n;
      col   <= col_n;
      if (load_cfg) begin
        first_q <= page_first;
        last_q  <= page_last;
        inv_q   <= invert;
      end
      // Read data is captured on the edge that closes the strobed phase.
      if (state == RD && last_phase && !abort) begin
        data_q <= bus_data_in;
      end
    end
  end

  always_comb begin
    state_n  = state;
    page_n   = page;
    col_n    = col;
    load_cfg = 1'b0;
    // A cycle without ack sends the current access back to phase 0.
    phase_n  = act ? ~phase : 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n  = REQ;
          load_cfg = 1'b1;
        end
      end
      REQ: begin
        if (bus_ack) begin
          if (first_q > last_q) begin
            state_n = DONE;
          end else begin
            state_n = COL_HI;
            page_n  = first_q;
            col_n   = '0;
          end
        end
      end
      COL_HI: if (last_phase) state_n = COL_LO;
      COL_LO: if (last_phase) state_n = PAGE;
      PAGE:   if (last_phase) state_n = RD;
      RD:     if (last_phase) state_n = WR;
      WR: begin
        if (last_phase) begin
          if (col != COL_LAST) begin
            col_n   = col + CW'(1);
            state_n = RD;
          end else begin
            col_n = '0;
            if (page < last_q) begin
              page_n  = page + PW'(1);
              state_n = COL_HI;
            end else begin
              state_n = DONE;
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (abort && state != IDLE) begin
      state_n = IDLE;
      phase_n = 1'b0;
    end
  end

  always_comb begin
    busy            = access || (state == REQ);
    bus_request     = busy;
    bus_status      = 2'd0;
    read            = 1'b0;
    write           = 1'b0;
    irq_copy_done   = (state == DONE) && !abort;
    bus_address_out = 24'h000000;
    bus_data_out    = 8'h00;

    if (act) begin
      bus_status = (state == RD) ? 2'd3 : 2'd2;
      read       = phase && !abort && (state == RD);
      write      = phase && !abort && (state != RD);
    end

    case (state)
      COL_HI: begin
        bus_address_out = LCD_CMD_ADDR;
        bus_data_out    = 8'h10;
      end
      COL_LO: begin
        bus_address_out = LCD_CMD_ADDR;
        bus_data_out    = 8'h00;
      end
      PAGE: begin
        bus_address_out = LCD_CMD_ADDR;
        bus_data_out    = {4'hB, 1'b0, page3};
      end
      RD: begin
        bus_address_out = fb_addr;
      end
      WR: begin
        bus_address_out = LCD_DATA_ADDR;
        bus_data_out    = data_q ^ {8{inv_q}};
      end
      default: begin
        bus_address_out = 24'h000000;
        bus_data_out    = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_prc_copy_dma.sv
// tb/tb_prc_copy_dma.sv - scoreboard bench for prc_copy_dma
// Directed copies; expected bus writes/reads are queued at start and popped as strobes appear.
module tb_prc_copy_dma;
  localparam logic [23:0] CMD  = 24'h20FE;
  localparam logic [23:0] DAT  = 24'h20FF;
  localparam logic [23:0] FB   = 24'h1000;
  localparam int          COLS = 96;

  logic        clk = 1'b0;
  logic        reset, start, abort, invert, bus_ack;
  logic [2:0]  page_first, page_last;
  logic        bus_request, read, write, busy, irq_copy_done;
  logic [23:0] bus_address_out;
  logic [7:0]  bus_data_out, bus_data_in;
  logic [1:0]  bus_status;
  logic        mem_3c;

  logic [31:0] wq[$];
  logic [23:0] rq[$];
  int          n_total, n_pass;
  int          acc, irqs, irq_at, rds, wrs, dwr;
  logic [23:0] first_rd;
  logic [1:0]  last_status;
  logic [23:0] last_addr;
  logic        last_read, last_write, busy_at_irq, req_at_irq;

  prc_copy_dma dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .page_first(page_first), .page_last(page_last), .invert(invert),
    .bus_request(bus_request), .bus_ack(bus_ack),
    .bus_address_out(bus_address_out), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .bus_status(bus_status),
    .read(read), .write(write), .busy(busy), .irq_copy_done(irq_copy_done)
  );

  always #5 clk = ~clk;

  // Framebuffer model: byte equals low address byte, or a constant pattern.
  always_comb bus_data_in = mem_3c ? 8'h3C : bus_address_out[7:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic sample();
    logic [31:0] e;
    last_status = bus_status;
    last_addr   = bus_address_out;
    last_read   = read;
    last_write  = write;
    if (bus_status != 2'd0) acc++;
    if (irq_copy_done) begin
      irqs++;
      irq_at      = acc;
      busy_at_irq = busy;
      req_at_irq  = bus_request;
    end
    if (write) begin
      wrs++;
      if (bus_address_out == DAT) dwr++;
      check("wr_status", 32'(bus_status), 32'd2);
      if (wq.size() == 0) begin
        check("wr_unexpected", {bus_address_out, bus_data_out}, 32'd0);
      end else begin
        e = wq.pop_front();
        check("wr_addr", 32'(bus_address_out), 32'(e[31:8]));
        check("wr_data", 32'(bus_data_out), 32'(e[7:0]));
      end
    end
    if (read) begin
      if (rds == 0) first_rd = bus_address_out;
      rds++;
      check("rd_status", 32'(bus_status), 32'd3);
      if (rq.size() == 0) begin
        check("rd_unexpected", 32'(bus_address_out), 32'd0);
      end else begin
        check("rd_addr", 32'(bus_address_out), 32'(rq.pop_front()));
      end
    end
  endtask

  task automatic step();
    #1;
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    acc = 0; irqs = 0; irq_at = -1; rds = 0; wrs = 0; dwr = 0;
    first_rd = 24'h0;
    wq.delete();
    rq.delete();
  endtask

  task automatic expect_copy(input int first, input int last, input logic inv);
    logic [23:0] a;
    logic [7:0]  d;
    for (int p = first; p <= last; p++) begin
      wq.push_back({CMD, 8'h10});
      wq.push_back({CMD, 8'h00});
      wq.push_back({CMD, 8'hB0 | 8'(p)});
      for (int c = 0; c < COLS; c++) begin
        a = FB + 24'(p * COLS + c);
        d = mem_3c ? 8'h3C : a[7:0];
        rq.push_back(a);
        wq.push_back({DAT, d ^ {8{inv}}});
      end
    end
  endtask

  task automatic start_copy(input int first, input int last, input logic inv);
    page_first = 3'(first);
    page_last  = 3'(last);
    invert     = inv;
    start      = 1'b1;
    step();
    start      = 1'b0;
    page_first = 3'd0;
    page_last  = 3'd0;
    invert     = 1'b0;
  endtask

  task automatic wait_irq(input int budget);
    int i0;
    i0 = irqs;
    for (int i = 0; i < budget && irqs == i0; i++) step();
    check("irq_seen", 32'(irqs), 32'(i0 + 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    32'(bus_request),     32'd0);
    check({tag, "_read"},   32'(read),            32'd0);
    check({tag, "_write"},  32'(write),           32'd0);
    check({tag, "_status"}, 32'(bus_status),      32'd0);
    check({tag, "_busy"},   32'(busy),            32'd0);
    check({tag, "_irq"},    32'(irq_copy_done),   32'd0);
    check({tag, "_addr"},   32'(bus_address_out), 32'd0);
    check({tag, "_data"},   32'(bus_data_out),    32'd0);
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; invert = 1'b0; bus_ack = 1'b1;
    page_first = 3'd0; page_last = 3'd0; mem_3c = 1'b0;
    clear_counts();
    @(posedge clk); #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Full default copy, pages 0..7.
    clear_counts();
    expect_copy(0, 7, 1'b0);
    start_copy(0, 7, 1'b0);
    check("busy_after_start", 32'(busy), 32'd1);
    check("req_after_start", 32'(bus_request), 32'd1);
    wait_irq(4000);
    check("full_irq_at", 32'(irq_at), 32'd3120);
    check("full_reads", 32'(rds), 32'd768);
    check("full_writes", 32'(wrs), 32'd792);
    check("full_wq_left", 32'(wq.size()), 32'd0);
    check("done_busy", 32'(busy_at_irq), 32'd0);
    check("done_req", 32'(req_at_irq), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    step();
    check("irq_once", 32'(irqs), 32'd1);

    // Inverted copy of a constant framebuffer; a second start mid-copy is ignored.
    clear_counts();
    mem_3c = 1'b1;
    expect_copy(0, 0, 1'b1);
    start_copy(0, 0, 1'b1);
    for (int i = 0; i < 20; i++) step();
    start_copy(5, 7, 1'b0);
    wait_irq(600);
    check("inv_irq_at", 32'(irq_at), 32'd390);
    check("inv_wq_left", 32'(wq.size()), 32'd0);
    mem_3c = 1'b0;

    // Partial page range.
    clear_counts();
    expect_copy(3, 5, 1'b0);
    start_copy(3, 5, 1'b0);
    wait_irq(1500);
    check("range_first_rd", 32'(first_rd), 32'h1120);
    check("range_irq_at", 32'(irq_at), 32'd1170);
    check("range_wq_left", 32'(wq.size()), 32'd0);

    // Reversed range: no accesses at all.
    clear_counts();
    start_copy(6, 2, 1'b0);
    wait_irq(20);
    check("empty_reads", 32'(rds), 32'd0);
    check("empty_writes", 32'(wrs), 32'd0);
    step();
    check("empty_irq_once", 32'(irqs), 32'd1);

    // Ack dropped for 5 cycles during RD phase 1 of the third column.
    clear_counts();
    expect_copy(0, 0, 1'b0);
    start_copy(0, 0, 1'b0);
    for (int i = 0; i < 200 && !(rds == 2 && last_status == 2'd3 && !last_read); i++) step();
    check("drop_armed", 32'(rds), 32'd2);
    bus_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("drop_read", 32'(last_read), 32'd0);
      check("drop_status", 32'(last_status), 32'd0);
    end
    bus_ack = 1'b1;
    wait_irq(600);
    check("drop_irq_at", 32'(irq_at), 32'd391);
    check("drop_reads", 32'(rds), 32'd96);
    check("drop_wq_left", 32'(wq.size()), 32'd0);

    // Abort during the 10th data write.
    clear_counts();
    expect_copy(0, 7, 1'b0);
    start_copy(0, 7, 1'b0);
    for (int i = 0; i < 200 && !(dwr == 9 && last_status == 2'd2 && last_addr == DAT && !last_write); i++) step();
    check("abort_armed", 32'(dwr), 32'd9);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_req", 32'(bus_request), 32'd0);
    check("abort_strobes", {30'd0, read, write}, 32'd0);
    check("abort_status", 32'(bus_status), 32'd0);
    for (int i = 0; i < 20; i++) step();
    check("abort_no_irq", 32'(irqs), 32'd0);
    wq.delete();
    rq.delete();

    // Start together with abort is rejected.
    abort = 1'b1;
    start_copy(0, 7, 1'b0);
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_req", 32'(bus_request), 32'd0);

    // Reset in the middle of a copy.
    clear_counts();
    expect_copy(0, 7, 1'b0);
    start_copy(0, 7, 1'b0);
    for (int i = 0; i < 37; i++) step();
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    wq.delete();
    rq.delete();
    for (int i = 0; i < 5; i++) step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_irq", 32'(irqs), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
